// File: rtl/fp_variants_pkg.sv
// Shared types and constants for the floating-point variant differential test harness.
// Default lane latencies are packed 4 bits per lane, lane 0 in the low nibble.
package fp_variants_pkg;

    localparam int WIDTH  = 32;
    localparam int FLAG_W = 3;

    localparam logic [15:0] DEFAULT_LATS = {4'd4, 4'd3, 4'd2, 4'd1};

    typedef logic [WIDTH-1:0]  fp_word_t;
    typedef logic [FLAG_W-1:0] fp_flags_t;

    localparam fp_word_t FP_ONE  = 32'h3f80_0000;
    localparam fp_word_t FP_TWO  = 32'h4000_0000;
    localparam fp_word_t FP_ZERO = 32'h0000_0000;

    // Extracts the latency of one lane from a packed latency vector.
    function automatic int lane_lat(input logic [63:0] lats, input int lane);
        return int'(lats[4*lane +: 4]);
    endfunction

endpackage

// File: rtl/fp_diff_checker_if.sv
// Operand/result bus between the variant pipelines and the differential checker.
// The master side issues operands and lane results; the slave side is the checker.
interface fp_diff_checker_if #(
    parameter int WIDTH        = fp_variants_pkg::WIDTH,
    parameter int NUM_VARIANTS = 4,
    parameter int FLAG_W       = fp_variants_pkg::FLAG_W,
    parameter int ERR_W        = 16
);

    logic                           clear;
    logic                           in_valid;
    logic [WIDTH-1:0]               in_a;
    logic [WIDTH-1:0]               in_b;
    logic [NUM_VARIANTS*WIDTH-1:0]  res;
    logic [NUM_VARIANTS*FLAG_W-1:0] flags;

    logic                           cmp_valid;
    logic                           mismatch;
    logic [31:0]                    test_count;
    logic [ERR_W-1:0]               err_count;
    logic                           first_err_valid;
    logic [WIDTH-1:0]               first_err_a;
    logic [WIDTH-1:0]               first_err_b;
    logic [31:0]                    first_err_idx;

    modport master (
        output clear, in_valid, in_a, in_b, res, flags,
        input  cmp_valid, mismatch, test_count, err_count,
               first_err_valid, first_err_a, first_err_b, first_err_idx
    );

    modport slave (
        input  clear, in_valid, in_a, in_b, res, flags,
        output cmp_valid, mismatch, test_count, err_count,
               first_err_valid, first_err_a, first_err_b, first_err_idx
    );

endinterface

// File: rtl/fp_delay_line.sv
// Fixed-depth register delay; DEPTH=0 degenerates to a plain wire.
// clr empties the held stages while still capturing the incoming word.
module fp_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctl;
        assign unused_ctl = clk ^ reset ^ clr;
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] stage_q [DEPTH];
        logic [W-1:0] stage_d [DEPTH];

        if (DEPTH == 1) begin : g_one
            logic unused_clr;
            assign unused_clr = clr;
        end

        always_comb begin
            stage_d[0] = d;
            for (int s = 1; s < DEPTH; s++) begin
                stage_d[s] = clr ? '0 : stage_q[s-1];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s < DEPTH; s++) begin
                    stage_q[s] <= '0;
                end
            end else begin
                for (int s = 0; s < DEPTH; s++) begin
                    stage_q[s] <= stage_d[s];
                end
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/fp_diff_checker.sv
// Latency-aligning differential checker: every lane is compared against lane 0 once all
// lanes of an issue line up. Define FP_DIFF_CHECK_FLAGS_EN to also compare per-lane flags.
module fp_diff_checker #(
    parameter int                        WIDTH        = fp_variants_pkg::WIDTH,
    parameter int                        NUM_VARIANTS = 4,
    parameter int                        FLAG_W       = fp_variants_pkg::FLAG_W,
    parameter int                        MAX_LAT      = 4,
    parameter logic [4*NUM_VARIANTS-1:0] LATS         = fp_variants_pkg::DEFAULT_LATS,
    parameter int                        ERR_W        = 16
) (
    input logic              clk,
    input logic              reset,
    fp_diff_checker_if.slave bus
);
    import fp_variants_pkg::*;

    localparam int TOK_W = 1 + 2*WIDTH;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [TOK_W-1:0] tok_in;
    logic [TOK_W-1:0] tok_out;
    logic             tok_valid;
    logic [WIDTH-1:0] tok_a;
    logic [WIDTH-1:0] tok_b;

    assign tok_in = {bus.in_valid, bus.in_a, bus.in_b};

    fp_delay_line #(.DEPTH(MAX_LAT), .W(TOK_W)) u_tok (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear),
        .d     (tok_in),
        .q     (tok_out)
    );

    assign {tok_valid, tok_a, tok_b} = tok_out;

    logic [WIDTH-1:0] lane_res [NUM_VARIANTS];
`ifdef FP_DIFF_CHECK_FLAGS_EN
    logic [FLAG_W-1:0] lane_flg [NUM_VARIANTS];
`else
    logic unused_flags;
    assign unused_flags = ^bus.flags;
`endif

    // Each lane is padded out to MAX_LAT so all lanes of one issue meet the token.
    for (genvar i = 0; i < NUM_VARIANTS; i++) begin : g_lane
        localparam int DLY = MAX_LAT - lane_lat(64'(LATS), i);

        fp_delay_line #(.DEPTH(DLY), .W(WIDTH)) u_res (
            .clk   (clk),
            .reset (reset),
            .clr   (1'b0),
            .d     (bus.res[WIDTH*i +: WIDTH]),
            .q     (lane_res[i])
        );
`ifdef FP_DIFF_CHECK_FLAGS_EN
        fp_delay_line #(.DEPTH(DLY), .W(FLAG_W)) u_flg (
            .clk   (clk),
            .reset (reset),
            .clr   (1'b0),
            .d     (bus.flags[FLAG_W*i +: FLAG_W]),
            .q     (lane_flg[i])
        );
`endif
    end

    logic any_diff;

    // Case inequality so an X or Z on any lane is reported rather than masked.
    always_comb begin
        any_diff = 1'b0;
        for (int l = 1; l < NUM_VARIANTS; l++) begin
            if (lane_res[l] !== lane_res[0]) any_diff = 1'b1;
`ifdef FP_DIFF_CHECK_FLAGS_EN
            if (lane_flg[l] !== lane_flg[0]) any_diff = 1'b1;
`endif
        end
    end

    logic             cmp_fire;
    logic             cmp_valid_q, cmp_valid_d;
    logic             mismatch_q, mismatch_d;
    logic [31:0]      test_count_q, test_count_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             first_err_valid_q, first_err_valid_d;
    logic [WIDTH-1:0] first_err_a_q, first_err_a_d;
    logic [WIDTH-1:0] first_err_b_q, first_err_b_d;
    logic [31:0]      first_err_idx_q, first_err_idx_d;

    // A clear flushes the token about to complete, so it neither pulses nor counts.
    always_comb begin
        cmp_fire          = tok_valid & ~bus.clear;
        cmp_valid_d       = cmp_fire;
        mismatch_d        = cmp_fire & any_diff;
        test_count_d      = test_count_q;
        err_count_d       = err_count_q;
        first_err_valid_d = first_err_valid_q;
        first_err_a_d     = first_err_a_q;
        first_err_b_d     = first_err_b_q;
        first_err_idx_d   = first_err_idx_q;

        if (bus.clear) begin
            test_count_d      = '0;
            err_count_d       = '0;
            first_err_valid_d = 1'b0;
            first_err_a_d     = '0;
            first_err_b_d     = '0;
            first_err_idx_d   = '0;
        end else if (cmp_fire) begin
            test_count_d = test_count_q + 32'd1;
            if (any_diff) begin
                if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_W'(1);
                if (!first_err_valid_q) begin
                    first_err_valid_d = 1'b1;
                    first_err_a_d     = tok_a;
                    first_err_b_d     = tok_b;
                    first_err_idx_d   = test_count_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_valid_q       <= 1'b0;
            mismatch_q        <= 1'b0;
            test_count_q      <= '0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_a_q     <= '0;
            first_err_b_q     <= '0;
            first_err_idx_q   <= '0;
        end else begin
            cmp_valid_q       <= cmp_valid_d;
            mismatch_q        <= mismatch_d;
            test_count_q      <= test_count_d;
            err_count_q       <= err_count_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_a_q     <= first_err_a_d;
            first_err_b_q     <= first_err_b_d;
            first_err_idx_q   <= first_err_idx_d;
        end
    end

    assign bus.cmp_valid       = cmp_valid_q;
    assign bus.mismatch        = mismatch_q;
    assign bus.test_count      = test_count_q;
    assign bus.err_count       = err_count_q;
    assign bus.first_err_valid = first_err_valid_q;
    assign bus.first_err_a     = first_err_a_q;
    assign bus.first_err_b     = first_err_b_q;
    assign bus.first_err_idx   = first_err_idx_q;

endmodule

// File: doc/fp_diff_checker.md
# fp_diff_checker

Latency-aligning differential result checker that sits directly downstream of the floating-point pipeline variants (adders or multipliers) under differential test. It tracks each issued operand pair, realigns every variant's result to a common cycle using that variant's known latency, and compares all lanes against lane 0. It counts tests and mismatches and latches the first failing operand pair, replacing ad-hoc settle-and-compare loops in benches.

## Interface
Parameters:
- WIDTH, 32: result/operand width.
- NUM_VARIANTS, 4: number of variant lanes (≥2).
- FLAG_W, 3: per-lane flag bits {exception, overflow, underflow}.
- MAX_LAT, 4: alignment depth; every lane latency ≤ MAX_LAT.
- LATS, {4'd4,4'd3,4'd2,4'd1}: packed lane latencies, lane i at [4i+:4], each 1..MAX_LAT.
- ERR_W, 16: mismatch counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous clear of counters, first-error record and in-flight tokens.
- in_valid  in  1  operand pair presented to all variants this cycle.
- in_a, in_b  in  WIDTH  operands (logged only).
- res  in  NUM_VARIANTS*WIDTH  lane results, lane i at [WIDTH*i+:WIDTH].
- flags  in  NUM_VARIANTS*FLAG_W  lane flags, same packing.
- cmp_valid  out  1  one-cycle pulse: a comparison completed.
- mismatch  out  1  qualified by cmp_valid: some lane differed from lane 0.
- test_count  out  32  completed comparisons, wraps.
- err_count  out  ERR_W  mismatches, saturates at all-ones.
- first_err_valid  out  1  sticky: first mismatch recorded.
- first_err_a, first_err_b  out  WIDTH  operands of first mismatch.
- first_err_idx  out  32  test_count value of first mismatching test.

## Operation
- Token pipeline: {in_valid, in_a, in_b} shifted MAX_LAT stages.
- Lane i sampled at cycle t+LATS[i] of an issue at t, then delayed MAX_LAT−LATS[i] cycles; all lanes valid together at t+MAX_LAT.
- Compare: lane i ≠ lane 0 (4-state inequality in simulation; X/Z counts as mismatch) on result, and on flags when enabled.
- On compare: cmp_valid=1, mismatch=any lane differs, test_count+=1, err_count+=mismatch (saturating). If mismatch and !first_err_valid: latch operands, first_err_idx=pre-increment test_count, set first_err_valid.
- Lanes are not held; variants must be fully pipelined (one issue per cycle, back-to-back allowed).
- clear: zero counters, first-error record and all token valids; in_valid in the clear cycle is still accepted as a new token. clear overrides a same-cycle counter update.
- Reset values: every output 0; all internal valids 0.

## Timing
- Issue at cycle t → cmp_valid/mismatch registered, visible t+MAX_LAT+1; counters and first-error record update on that same edge.
- Throughput one comparison per cycle.
- Reset mid-operation: outputs drop to 0 asynchronously; in-flight tokens discarded; no cmp_valid for tokens issued before deassertion.
- err_count at all-ones stays all-ones; test_count wraps to 0 with no side effects.

## Configuration
- FP_DIFF_CHECK_FLAGS_EN defined: flags compared per lane; any flag difference asserts mismatch.
- Undefined: flags port present but ignored; only res compared; no flag delay registers instantiated.

## Structure
- Package fp_variants_pkg: WIDTH, FLAG_W, default LATS, typedef fp_word_t, fp_flags_t, special constants (FP_ONE=32'h3f800000, FP_TWO=32'h40000000, FP_ZERO).
- Sub-module fp_delay_line (DEPTH, W; DEPTH=0 pure passthrough), instantiated for token pipe and per-lane alignment.

## Test plan
- Issue 3f800000/40000000 with all lanes returning 40400000 at their latencies → cmp_valid at t+5, mismatch=0, test_count=1, err_count=0.
- Same, lane 2 returns 40400001 → mismatch=1, err_count=1, first_err_a=3f800000, first_err_b=40000000, first_err_idx=0.
- 8 back-to-back issues, only test 5 corrupt on lane 3 → eight consecutive cmp_valid pulses, test_count=8, err_count=1, first_err_idx=5.
- Lane 1 overflow flag=1, others 0, results equal → mismatch=1 with FP_DIFF_CHECK_FLAGS_EN; mismatch=0 without.
- ERR_W=4, 20 consecutive mismatching tests → err_count=15, test_count=20; clear then one clean test → err_count=0, test_count=1, first_err_valid=0.
- Reset asserted 2 cycles after issue → all outputs 0 immediately; no cmp_valid afterward.
